// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative, write-through, no-write-allocate read cache in front of the SRAM controller.
// Define CACHE_STATS_EN to add saturating hit/miss/write counters.
module cache_controller #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        pause,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_writeData,
  input  logic [63:0] sram_readData,
  input  logic        sram_pause
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wr_count
`endif
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - 3 - INDEX_W;
  localparam logic [1:0] IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2;
  logic [1:0] state_q, state_d;
  logic [SETS-1:0] valid_q [2];
  logic [SETS-1:0] lru_q;
  logic [TAG_W-1:0] tag_q [2][SETS];
  logic [63:0] data_q [2][SETS];
  logic off, hit0, hit1, hit, hit_way, victim, rd_hit;
  logic fill, upd, lru_we, lru_way, pause_c, rd_en_c, wr_en_c;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [63:0] hit_line;
  logic [31:0] hit_word, sram_word, rdata_c;
  logic unused_addr_bits;
  assign off = address[2];
  assign idx = address[INDEX_W+2:3];
  assign tag = address[ADDR_W-1:INDEX_W+3];
  assign unused_addr_bits = ^{address[31:ADDR_W], address[1:0]};
  assign hit0 = valid_q[0][idx] && tag_q[0][idx] == tag;
  assign hit1 = valid_q[1][idx] && tag_q[1][idx] == tag;
  assign hit = hit0 | hit1;
  assign hit_way = ~hit0;
  assign hit_line = data_q[hit_way][idx];
  assign hit_word = off ? hit_line[63:32] : hit_line[31:0];
  assign sram_word = off ? sram_readData[63:32] : sram_readData[31:0];
  assign victim = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
  assign rd_hit = state_q == IDLE && !MEM_W_EN && MEM_R_EN && hit;
  always_comb begin
    state_d = state_q;
    pause_c = 1'b0;
    rd_en_c = 1'b0;
    wr_en_c = 1'b0;
    rdata_c = '0;
    fill = 1'b0;
    upd = 1'b0;
    lru_we = 1'b0;
    lru_way = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_W_EN) begin
          wr_en_c = 1'b1;
          pause_c = 1'b1;
          state_d = WR_THRU;
        end else if (rd_hit) begin
          rdata_c = hit_word;
          lru_we = 1'b1;
          lru_way = hit_way;
        end else if (MEM_R_EN) begin
          rd_en_c = 1'b1;
          pause_c = 1'b1;
          state_d = RD_MISS;
        end
      end
      RD_MISS: begin
        rd_en_c = 1'b1;
        pause_c = sram_pause;
        if (!sram_pause) begin
          rdata_c = sram_word;
          fill = 1'b1;
          lru_we = 1'b1;
          lru_way = victim;
          state_d = IDLE;
        end
      end
      WR_THRU: begin
        wr_en_c = 1'b1;
        pause_c = sram_pause;
        if (!sram_pause) begin
          upd = hit;
          lru_we = hit;
          lru_way = hit_way;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Reset must silence the SRAM handshake at once, even with a request still held upstream.
  assign pause = rst & pause_c;
  assign sram_rd_en = rst & rd_en_c;
  assign sram_wr_en = rst & wr_en_c;
  assign readData = rst ? rdata_c : '0;
  assign sram_address = address;
  assign sram_writeData = writeData;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      lru_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill) valid_q[victim][idx] <= 1'b1;
      if (lru_we) lru_q[idx] <= ~lru_way;
    end
  end
  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[victim][idx] <= sram_readData;
      tag_q[victim][idx] <= tag;
    end
    if (upd && off) data_q[hit_way][idx][63:32] <= writeData;
    if (upd && !off) data_q[hit_way][idx][31:0] <= writeData;
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count <= '0;
      miss_count <= '0;
      wr_count <= '0;
    end else begin
      if (rd_hit && ~&hit_count) hit_count <= hit_count + 32'd1;
      if (fill && ~&miss_count) miss_count <= miss_count + 32'd1;
      if (state_q == WR_THRU && !sram_pause && ~&wr_count) wr_count <= wr_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized scoreboard bench; reference is an LRU-ordered tag list per set over a flat word memory.
module tb_cache_controller;
  logic clk = 1'b0, rst = 1'b0;
  logic MEM_R_EN = 1'b0, MEM_W_EN = 1'b0;
  logic [31:0] address = '0, writeData = '0;
  logic [31:0] readData, sram_address, sram_writeData;
  logic pause, sram_rd_en, sram_wr_en, sram_pause;
  logic [63:0] sram_readData = '0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wr_count;
`endif
  always #5 clk = ~clk;

  cache_controller dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .address(address), .writeData(writeData), .readData(readData), .pause(pause),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en), .sram_address(sram_address),
    .sram_writeData(sram_writeData), .sram_readData(sram_readData), .sram_pause(sram_pause)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wr_count(wr_count)
`endif
  );

  // SRAM controller model: busy for `busy` cycles of an access, then ready for one.
  int busy = 1, cnt = 0;
  assign sram_pause = (sram_rd_en | sram_wr_en) && cnt != busy;
  always @(posedge clk or negedge rst)
    if (!rst) cnt <= 0;
    else cnt <= ((sram_rd_en | sram_wr_en) && cnt != busy) ? cnt + 1 : 0;

  typedef struct {logic is_rd; logic [31:0] data; int stalls; logic exp_rd; logic exp_wr;} exp_t;
  exp_t exp_q[$];
  logic [31:0] mem [logic [16:0]];
  int unsigned sets[64][$];
  int vectors = 0, miscompares = 0;
  int n_hit = 0, n_miss = 0, n_wr = 0;

  function automatic logic [31:0] word(input logic [16:0] k);
    return mem.exists(k) ? mem[k] : ({15'b0, k} * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd, input int b);
    exp_t e;
    logic [16:0] k = a[18:2];
    int idx = int'(a[8:3]);
    int unsigned tg = a[18:9];
    int pos = -1;
    int n;
    foreach (sets[idx][i]) if (sets[idx][i] == tg) pos = i;
    e.is_rd = r && !w;
    e.exp_wr = w;
    e.exp_rd = r && !w && pos < 0;
    e.stalls = (w || pos < 0) ? b : 0;
    e.data = word(k);
    if (pos >= 0 && (w || r)) begin
      sets[idx].delete(pos);
      sets[idx].push_back(tg);
    end
    if (w) begin
      mem[k] = wd;
      n_wr++;
    end else if (pos >= 0) n_hit++;
    else begin
      if (sets[idx].size() == 2) void'(sets[idx].pop_front());
      sets[idx].push_back(tg);
      n_miss++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    MEM_R_EN = r;
    MEM_W_EN = w;
    address = a;
    writeData = wd;
    busy = b;
    sram_readData = {word({k[16:1], 1'b1}), word({k[16:1], 1'b0})};
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!pause) break;
    end
    if (n == 100) begin
      $display("FAIL timeout: pause stuck high at %h", a);
      $fatal(1);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      MEM_R_EN = 1'b0;
      MEM_W_EN = 1'b0;
    end
  endtask

  // Monitor: scores every completed request against the queued expectation.
  int stall = 0;
  logic saw_rd = 1'b0, saw_wr = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stall = 0;
      saw_rd = 1'b0;
      saw_wr = 1'b0;
    end else if (MEM_R_EN || MEM_W_EN) begin
      saw_rd |= sram_rd_en;
      saw_wr |= sram_wr_en;
      if (pause) stall++;
      else begin
        if (exp_q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("stall_cycles", stall, e.stalls);
          chk("sram_rd_en_seen", {31'b0, saw_rd}, {31'b0, e.exp_rd});
          chk("sram_wr_en_seen", {31'b0, saw_wr}, {31'b0, e.exp_wr});
          if (e.is_rd) chk("readData", readData, e.data);
        end
        stall = 0;
        saw_rd = 1'b0;
        saw_wr = 1'b0;
      end
    end else begin
      chk("idle_pause", {31'b0, pause}, 32'd0);
      chk("idle_enables", {30'b0, sram_rd_en, sram_wr_en}, 32'd0);
      chk("idle_readData", readData, 32'd0);
    end
  end

  initial begin
    logic [31:0] a;
    int op;
    repeat (3) @(negedge clk);
    chk("reset_pause", {31'b0, pause}, 32'd0);
    chk("reset_enables", {30'b0, sram_rd_en, sram_wr_en}, 32'd0);
    chk("reset_readData", readData, 32'd0);
    #1 rst = 1'b1;
    idle(2);
    txn(1, 0, 32'h404, 0, 6);
    txn(1, 0, 32'h404, 0, 3);
    txn(1, 0, 32'h408, 0, 2);
    txn(1, 0, 32'h604, 0, 4);
    txn(1, 0, 32'h404, 0, 1);
    txn(1, 0, 32'h804, 0, 5);
    txn(1, 0, 32'h404, 0, 1);
    txn(1, 0, 32'h604, 0, 2);
    txn(0, 1, 32'h404, 32'hDEADBEEF, 6);
    txn(1, 0, 32'h404, 0, 3);
    txn(1, 0, 32'h400, 0, 3);
    txn(0, 1, 32'h1000, 32'hCAFEF00D, 2);
    txn(1, 0, 32'h1000, 0, 2);
    txn(1, 1, 32'h404, 32'h12345678, 3);
    txn(1, 0, 32'h404, 0, 1);
    idle(1);
    for (int i = 0; i < 300; i++) begin
      a = {$urandom_range(0, 8191), 19'b0} | ($urandom_range(0, 3) << 9) | ($urandom_range(0, 2) << 3) | ($urandom_range(0, 1) << 2);
      op = $urandom_range(0, 9);
      txn(op < 6 || op == 9, op >= 6, a, $urandom, $urandom_range(1, 6));
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(2);
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, n_hit);
    chk("miss_count", miss_count, n_miss);
    chk("wr_count", wr_count, n_wr);
`endif
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b1;
    address = 32'h7FE28;
    busy = 6;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_pause", {31'b0, pause}, 32'd0);
    chk("rst_mid_enables", {30'b0, sram_rd_en, sram_wr_en}, 32'd0);
    chk("rst_mid_readData", readData, 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_counters", hit_count | miss_count | wr_count, 32'd0);
    n_hit = 0;
    n_miss = 0;
    n_wr = 0;
`endif
    exp_q.delete();
    foreach (sets[i]) sets[i].delete();
    MEM_R_EN = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    txn(1, 0, 32'h404, 0, 3);
    txn(1, 0, 32'h404, 0, 3);
    idle(2);
`ifdef CACHE_STATS_EN
    chk("hit_count_after_rst", hit_count, n_hit);
    chk("miss_count_after_rst", miss_count, n_miss);
`endif
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
